// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and defaults for the FIFO read-side stream master.
package fifo_stream_reader_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int PKT_LEN_DEF = 4;
    localparam int CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

    // Occupancy is the state encoding itself, kept behind a function so callers never depend on it.
    function automatic logic [1:0] occ_of(input buf_state_e s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_skid_buf.sv
// Two-entry FIFO-ordered register buffer; head drives the registered stream outputs.
module stream_skid_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              valid_o,
    output logic [1:0]        occ_o
);

    buf_state_e        state_q, state_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic              valid_q;

    // Next-state and entry movement for the occupancy FSM
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            ST_EMPTY: begin
                if (push_i) begin
                    state_d = ST_ONE;
                    head_d  = push_data_i;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (push_i && !pop_i) begin
                    state_d = ST_TWO;
                    tail_d  = push_data_i;
                end else if (push_i && pop_i) begin
                    head_d  = push_data_i;
                end else if (pop_i) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_ONE;
                end
            end
            ST_TWO: begin
                // Push while full cannot happen under the reader's credit rule; shift anyway if it does.
                if (pop_i) begin
                    state_d = push_i ? ST_TWO : ST_ONE;
                    head_d  = tail_q;
                    tail_d  = push_i ? push_data_i : tail_q;
                end else begin
                    state_d = ST_TWO;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (clr_i) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = state_d;
        end
    end

    // Buffer state and entry registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= (state_d != ST_EMPTY);
        end
    end

    assign head_o  = head_q;
    assign valid_o = valid_q;
    assign occ_o   = occ_of(state_q);

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read master: credit-based read issue, one-cycle capture into a skid buffer, framed output stream.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PKT_LEN = PKT_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_r_en,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int              IDX_W    = 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    logic [1:0]        occ_s;
    logic              valid_s;
    logic [DATA_W-1:0] head_s;
    logic              pop_s;
    logic              push_s;
    logic              rd_en_s;
    logic              last_s;
    logic [2:0]        credit_s;
    logic              inflight_q, inflight_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

    assign pop_s    = valid_s && m_ready;
    assign push_s   = inflight_q && !flush;
    assign last_s   = (idx_q == LAST_IDX);
    // Entries that will be held after this edge if we do not read: must leave room for one more.
    assign credit_s = {1'b0, occ_s} + {2'b00, inflight_q} - {2'b00, pop_s};

    // Read issue; a read is only in flight when the FIFO actually accepted it
    always_comb begin
        rd_en_s = 1'b0;
        if (rst_n && !fifo_empty && !flush && (credit_s < 3'd2)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
        inflight_d = rd_en_s;
    end

    // Frame index and completed-frame counter; flush restarts the frame but keeps the count
    always_comb begin
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        if (pop_s && last_s) begin
            idx_d       = '0;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end else if (pop_s) begin
            idx_d = idx_q + IDX_W'(1);
        end else begin
            idx_d = idx_q;
        end
        if (flush) begin
            idx_d = '0;
        end else begin
            idx_d = idx_d;
        end
    end

    // In-flight flag and framing registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q  <= 1'b0;
            idx_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            inflight_q  <= inflight_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    stream_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (flush),
        .push_i      (push_s),
        .push_data_i (fifo_rdata),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .valid_o     (valid_s),
        .occ_o       (occ_s)
    );

    assign fifo_r_en = rd_en_s;
    assign m_valid   = valid_s;
    assign m_data    = head_s;
    assign m_last    = valid_s && last_s;
    assign frame_cnt = frame_cnt_q;

endmodule
